// File: rtl/audio_i2s_tx_pkg.sv
// Shared types and constants for the I2S audio transmitter.
package audio_i2s_tx_pkg;

  // Slot index width; covers frames of up to 64 slots (SAMPLE_WIDTH <= 32).
  localparam int unsigned SLOT_W     = 6;
  localparam int unsigned UNDERRUN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } tx_state_e;

  // Increment that sticks at all-ones.
  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + UNDERRUN_W'(1);
  endfunction

endpackage

// File: rtl/audio_sat_conv.sv
// Arithmetic right shift of a signed FIFO word, then saturation to a signed sample.
module audio_sat_conv #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SHIFT        = 0
) (
  input  logic [DATA_WIDTH-1:0]   i_din,
  output logic [SAMPLE_WIDTH-1:0] o_sample_c
);

  logic signed [DATA_WIDTH-1:0]         w_shifted;
  logic        [DATA_WIDTH-SAMPLE_WIDTH:0] w_upper;
  logic                                  w_in_range;

  assign w_shifted  = $signed(i_din) >>> SHIFT;
  // In range when every bit from the sample sign bit upward agrees.
  assign w_upper    = w_shifted[DATA_WIDTH-1:SAMPLE_WIDTH-1];
  assign w_in_range = (&w_upper) | ~(|w_upper);

  // Pass through in range, otherwise clamp to the most positive/negative code.
  always_comb begin
    o_sample_c = w_shifted[SAMPLE_WIDTH-1:0];
    if (!w_in_range) begin
      o_sample_c = w_shifted[DATA_WIDTH-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                           : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: pulls stereo pairs from two FIFOs, saturates them and
// serializes them MSB first, one bit slot late relative to lrclk.
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SHIFT        = 0,
  parameter int unsigned BCLK_DIV     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_left_dout,
  input  logic [DATA_WIDTH-1:0] i_right_dout,
  input  logic                  i_left_empty,
  input  logic                  i_right_empty,
  output logic                  o_out_rd_en,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_frame_active,
  output logic [UNDERRUN_W-1:0] o_underrun_count
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned SW    = SAMPLE_WIDTH;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MID  = SLOT_W'(SAMPLE_WIDTH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * SAMPLE_WIDTH - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div, w_div_nxt;
  logic [SLOT_W-1:0]     r_slot, w_slot_nxt;
  logic                  r_bclk, w_bclk_nxt;
  logic                  r_lrclk, w_lrclk_nxt;
  logic                  r_sdata, w_sdata_nxt;
  logic                  r_rd_en, w_rd_en_nxt;
  logic                  r_rd_d;
  logic                  r_frame_active;
  logic [UNDERRUN_W-1:0] r_underrun, w_underrun_nxt;
  logic [SW-1:0]         r_sh_l, w_sh_l_nxt;
  logic [SW-1:0]         r_sh_r, w_sh_r_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic [SW-1:0]         r_pend_l, w_pend_l_nxt;
  logic [SW-1:0]         r_pend_r, w_pend_r_nxt;

  logic [SW-1:0]         w_conv_l, w_conv_r;
  logic                  w_fifo_ready;
  logic                  w_div_end;
  logic [SLOT_W-1:0]     w_slot_inc;

  audio_sat_conv #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .SHIFT       (SHIFT)
  ) u_conv_l (
    .i_din     (i_left_dout),
    .o_sample_c(w_conv_l)
  );

  audio_sat_conv #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .SHIFT       (SHIFT)
  ) u_conv_r (
    .i_din     (i_right_dout),
    .o_sample_c(w_conv_r)
  );

  assign w_fifo_ready = ~i_left_empty & ~i_right_empty;
  assign w_div_end    = (r_div == DIV_LAST);
  assign w_slot_inc   = r_slot + SLOT_W'(1);

  assign o_out_rd_en      = r_rd_en;
  assign o_bclk           = r_bclk;
  assign o_lrclk          = r_lrclk;
  assign o_sdata          = r_sdata;
  assign o_frame_active   = r_frame_active;
  assign o_underrun_count = r_underrun;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_slot_nxt     = r_slot;
    w_bclk_nxt     = r_bclk;
    w_lrclk_nxt    = r_lrclk;
    w_sdata_nxt    = r_sdata;
    w_rd_en_nxt    = 1'b0;
    w_underrun_nxt = r_underrun;
    w_sh_l_nxt     = r_sh_l;
    w_sh_r_nxt     = r_sh_r;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_l_nxt   = r_pend_l;
    w_pend_r_nxt   = r_pend_r;

    // FIFO words are valid the cycle after the read pulse.
    if (r_rd_d) begin
      w_pend_l_nxt   = w_conv_l;
      w_pend_r_nxt   = w_conv_r;
      w_pend_vld_nxt = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: begin
        w_bclk_nxt  = 1'b0;
        w_lrclk_nxt = 1'b0;
        w_sdata_nxt = 1'b0;
        w_div_nxt   = '0;
        w_slot_nxt  = '0;
        if (i_enable) begin
          if (r_pend_vld) begin
            // Fresh start: slot 0 carries no previous right LSB.
            w_state_nxt    = ST_RUN;
            w_sh_l_nxt     = r_pend_l;
            w_sh_r_nxt     = r_pend_r;
            w_pend_vld_nxt = 1'b0;
          end else if (w_fifo_ready) begin
            w_state_nxt = ST_PRIME;
            w_rd_en_nxt = 1'b1;
          end
        end
      end

      ST_PRIME: w_state_nxt = ST_LOAD;

      ST_LOAD:  w_state_nxt = ST_IDLE;

      ST_RUN: begin
        if (w_div_end) begin
          w_div_nxt  = '0;
          w_bclk_nxt = ~r_bclk;
          if (r_bclk) begin
            if (r_slot == SLOT_LAST) begin
              // Frame boundary: slot 0 of the next frame is the old right LSB.
              w_slot_nxt  = '0;
              w_lrclk_nxt = 1'b0;
              w_sdata_nxt = r_sh_r[SW-1];
              if (i_enable) begin
                if (r_pend_vld) begin
                  w_sh_l_nxt     = r_pend_l;
                  w_sh_r_nxt     = r_pend_r;
                  w_pend_vld_nxt = 1'b0;
                end else begin
                  w_sh_l_nxt     = '0;
                  w_sh_r_nxt     = '0;
                  w_underrun_nxt = sat_inc(r_underrun);
                end
              end else begin
                w_state_nxt = ST_DRAIN;
              end
            end else begin
              w_slot_nxt  = w_slot_inc;
              w_lrclk_nxt = (w_slot_inc >= SLOT_MID);
              if (w_slot_inc <= SLOT_MID) begin
                w_sdata_nxt = r_sh_l[SW-1];
                w_sh_l_nxt  = {r_sh_l[SW-2:0], 1'b0};
              end else begin
                w_sdata_nxt = r_sh_r[SW-1];
                w_sh_r_nxt  = {r_sh_r[SW-2:0], 1'b0};
              end
              // Prefetch the next pair at the start of the right half.
              if ((w_slot_inc == SLOT_MID) && !r_pend_vld && w_fifo_ready) begin
                w_rd_en_nxt = 1'b1;
              end
            end
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      ST_DRAIN: begin
        if (w_div_end) begin
          w_div_nxt  = '0;
          w_bclk_nxt = ~r_bclk;
          if (r_bclk) begin
            w_state_nxt = ST_IDLE;
            w_lrclk_nxt = 1'b0;
            w_sdata_nxt = 1'b0;
            w_slot_nxt  = '0;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_div          <= '0;
      r_slot         <= '0;
      r_bclk         <= 1'b0;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_rd_en        <= 1'b0;
      r_rd_d         <= 1'b0;
      r_frame_active <= 1'b0;
      r_underrun     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_div          <= w_div_nxt;
      r_slot         <= w_slot_nxt;
      r_bclk         <= w_bclk_nxt;
      r_lrclk        <= w_lrclk_nxt;
      r_sdata        <= w_sdata_nxt;
      r_rd_en        <= w_rd_en_nxt;
      r_rd_d         <= r_rd_en;
      r_frame_active <= (w_state_nxt != ST_IDLE);
      r_underrun     <= w_underrun_nxt;
    end
  end

  // Shift registers and the pending sample pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_l     <= '0;
      r_sh_r     <= '0;
      r_pend_vld <= 1'b0;
      r_pend_l   <= '0;
      r_pend_r   <= '0;
    end else begin
      r_sh_l     <= w_sh_l_nxt;
      r_sh_r     <= w_sh_r_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_l   <= w_pend_l_nxt;
      r_pend_r   <= w_pend_r_nxt;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: FIFO model, I2S receiver and a
// frame-level reference model of the expected slot stream.
module tb_audio_i2s_tx;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 16;
  localparam int unsigned SHIFT = 0;
  localparam int unsigned BDIV  = 4;
  localparam int          FSLOTS = 2 * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [DW-1:0] l_dout = '0;
  logic [DW-1:0] r_dout = '0;
  logic          l_empty = 1'b1;
  logic          r_empty = 1'b1;
  logic          rd_en, bclk, lrclk, sdata, fact;
  logic [15:0]   urun;

  audio_i2s_tx #(
    .DATA_WIDTH  (DW),
    .SAMPLE_WIDTH(SW),
    .SHIFT       (SHIFT),
    .BCLK_DIV    (BDIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .i_left_dout     (l_dout),
    .i_right_dout    (r_dout),
    .i_left_empty    (l_empty),
    .i_right_empty   (r_empty),
    .o_out_rd_en     (rd_en),
    .o_bclk          (bclk),
    .o_lrclk         (lrclk),
    .o_sdata         (sdata),
    .o_frame_active  (fact),
    .o_underrun_count(urun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_l[$], fifo_r[$];
  logic [DW-1:0] mdl_l[$], mdl_r[$];
  bit            rx_d[$], rx_lr[$], exp_d[$], exp_lr[$];
  int            lr_rise[$];
  int            cyc = 0;
  int            rd_cnt = 0;
  int            rd_viol = 0;
  bit            pop_next = 1'b0;
  int            exp_urun = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion: shift, then clamp to the signed sample range.
  function automatic logic [SW-1:0] conv(input logic [DW-1:0] d);
    longint v;
    v = longint'($signed(d)) >>> SHIFT;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return SW'(v);
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom());
      1:       v = int'($urandom_range(0, 65535)) - 32768;
      2:       v = (($urandom_range(0, 1) == 1) ? 32767 : -32768) + int'($urandom_range(0, 2)) - 1;
      default: v = int'($urandom_range(0, 200000)) - 100000;
    endcase
    return DW'(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    fifo_l.push_back(l);
    fifo_r.push_back(r);
    mdl_l.push_back(l);
    mdl_r.push_back(r);
    l_empty = 1'b0;
    r_empty = 1'b0;
  endtask

  task automatic clear_rx();
    rx_d.delete();
    rx_lr.delete();
    lr_rise.delete();
  endtask

  // Expected slot stream for a run of nframes starting from idle.
  task automatic build_run(input int nframes, input bit drain);
    logic [SW-1:0] ls, rs;
    bit prev;
    prev = 1'b0;
    exp_d.delete();
    exp_lr.delete();
    for (int f = 0; f < nframes; f++) begin
      if (mdl_l.size() > 0) begin
        ls = conv(mdl_l.pop_front());
        rs = conv(mdl_r.pop_front());
      end else begin
        ls = '0;
        rs = '0;
        if (exp_urun < 65535) exp_urun++;
      end
      for (int k = 0; k < FSLOTS; k++) begin
        exp_lr.push_back(k >= int'(SW));
        if (k == 0)             exp_d.push_back(prev);
        else if (k <= int'(SW)) exp_d.push_back(ls[int'(SW) - k]);
        else                    exp_d.push_back(rs[FSLOTS - k]);
      end
      prev = rs[0];
    end
    if (drain) begin
      exp_lr.push_back(1'b0);
      exp_d.push_back(prev);
    end
  endtask

  task automatic compare_stream(input string tag, input int n);
    logic [31:0] gd, gl, ed, el;
    check_eq({tag, "_slots"}, 64'(rx_d.size()), 64'(n));
    for (int i = 0; i < n; i += 32) begin
      gd = '0; gl = '0; ed = '0; el = '0;
      for (int j = i; (j < i + 32) && (j < n); j++) begin
        gd = {gd[30:0], (j < rx_d.size()) ? rx_d[j] : 1'b0};
        gl = {gl[30:0], (j < rx_lr.size()) ? rx_lr[j] : 1'b0};
        ed = {ed[30:0], exp_d[j]};
        el = {el[30:0], exp_lr[j]};
      end
      check_eq($sformatf("%s_sdata%0d", tag, i / 32), 64'(gd), 64'(ed));
      check_eq($sformatf("%s_lrclk%0d", tag, i / 32), 64'(gl), 64'(el));
    end
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t;
    t = 0;
    while ((rx_d.size() < n) && (t < 20000)) begin
      tick(1);
      t++;
    end
    if (rx_d.size() < n) check_eq({tag, "_timeout"}, 64'(rx_d.size()), 64'(n));
  endtask

  // Drop enable in slot 5 of the last frame, then wait for the drain to finish.
  task automatic run_stop(input int nframes, input string tag);
    int t;
    wait_rx(FSLOTS * (nframes - 1) + 6, tag);
    i_enable = 1'b0;
    t = 0;
    while (fact && (t < 3000)) begin
      tick(1);
      t++;
    end
    check_eq({tag, "_idle"}, 64'(fact), 64'(0));
    tick(20);
  endtask

  // FIFO model (data valid the cycle after a read) and I2S receiver.
  initial begin : monitor
    bit pb, pl, prd;
    pb = 1'b0; pl = 1'b0; prd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pop_next) begin
        if (fifo_l.size() > 0) l_dout = fifo_l.pop_front();
        if (fifo_r.size() > 0) r_dout = fifo_r.pop_front();
        l_empty = (fifo_l.size() == 0);
        r_empty = (fifo_r.size() == 0);
      end
      pop_next = rd_en;
      if (rd_en) begin
        rd_cnt++;
        if (prd || l_empty || r_empty) rd_viol++;
      end
      if (bclk && !pb) begin
        rx_d.push_back(sdata);
        rx_lr.push_back(lrclk);
      end
      if (lrclk && !pl) lr_rise.push_back(cyc);
      pb = bclk; pl = lrclk; prd = rd_en;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit any;
    int start_rd, period, nf, m;

    rst_n = 1'b0;
    tick(3);
    check_eq("rst_bclk",  64'(bclk),  64'(0));
    check_eq("rst_lrclk", 64'(lrclk), 64'(0));
    check_eq("rst_sdata", 64'(sdata), 64'(0));
    check_eq("rst_rd_en", 64'(rd_en), 64'(0));
    check_eq("rst_fact",  64'(fact),  64'(0));
    check_eq("rst_urun",  64'(urun),  64'(0));

    // Empty FIFOs with enable high: nothing moves.
    rst_n = 1'b1;
    i_enable = 1'b1;
    any = 1'b0;
    repeat (300) begin
      tick(1);
      if (bclk | lrclk | sdata | rd_en | fact) any = 1'b1;
    end
    check_eq("empty_outs", 64'(any), 64'(0));
    check_eq("empty_rd",   64'(rd_cnt), 64'(0));
    check_eq("empty_urun", 64'(urun), 64'(0));
    i_enable = 1'b0;
    tick(2);

    // One sample, then an underrun frame, then drain.
    clear_rx();
    start_rd = rd_cnt;
    push_pair(32'h0000_1234, 32'hFFFF_FF00);
    i_enable = 1'b1;
    run_stop(2, "basic");
    build_run(2, 1'b1);
    compare_stream("basic", 2 * FSLOTS + 1);
    check_eq("basic_rd_cnt", 64'(rd_cnt - start_rd), 64'(1));
    check_eq("basic_urun", 64'(urun), 64'(exp_urun));
    period = (lr_rise.size() >= 2) ? (lr_rise[1] - lr_rise[0]) : -1;
    check_eq("basic_frame_clks", 64'(period), 64'(FSLOTS * 2 * BDIV));

    // Saturation in both directions, enable dropped at slot 5.
    clear_rx();
    start_rd = rd_cnt;
    push_pair(32'h0001_2345, 32'hFFFE_0000);
    i_enable = 1'b1;
    run_stop(1, "sat");
    build_run(1, 1'b1);
    compare_stream("sat", FSLOTS + 1);
    check_eq("sat_rd_cnt", 64'(rd_cnt - start_rd), 64'(1));
    check_eq("sat_urun", 64'(urun), 64'(exp_urun));

    // Idle with data waiting and enable low: no reads, no clocks.
    start_rd = rd_cnt;
    push_pair(rnd_word(), rnd_word());
    tick(200);
    check_eq("idle_no_rd", 64'(rd_cnt - start_rd), 64'(0));
    check_eq("idle_fact",  64'(fact), 64'(0));
    check_eq("idle_slots", 64'(rx_d.size()), 64'(FSLOTS + 1));

    // Randomized runs; leftover samples carry across runs via the pending pair.
    for (int it = 0; it < 3; it++) begin
      m  = int'($urandom_range(1, 5));
      nf = int'($urandom_range(2, 7));
      for (int s = 0; s < m; s++) push_pair(rnd_word(), rnd_word());
      clear_rx();
      i_enable = 1'b1;
      run_stop(nf, $sformatf("rnd%0d", it));
      build_run(nf, 1'b1);
      compare_stream($sformatf("rnd%0d", it), nf * FSLOTS + 1);
      check_eq($sformatf("rnd%0d_urun", it), 64'(urun), 64'(exp_urun));
    end

    // Reset in slot 20 of a running frame.
    for (int s = 0; s < 3; s++) push_pair(rnd_word(), rnd_word());
    clear_rx();
    i_enable = 1'b1;
    wait_rx(21, "rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", 64'({bclk, lrclk, sdata, fact, rd_en, urun}), 64'(0));
    fifo_l.delete(); fifo_r.delete();
    mdl_l.delete();  mdl_r.delete();
    l_empty = 1'b1;  r_empty = 1'b1;
    pop_next = 1'b0;
    exp_urun = 0;
    tick(3);
    rst_n = 1'b1;
    clear_rx();
    tick(30);
    check_eq("rst_no_resume", 64'({fact, bclk}), 64'(0));
    start_rd = rd_cnt;
    push_pair(rnd_word(), rnd_word());
    tick(1);
    check_eq("restart_prime", 64'({rd_en, fact}), 64'(2'b11));
    run_stop(1, "restart");
    build_run(1, 1'b1);
    compare_stream("restart", FSLOTS + 1);
    check_eq("restart_rd_cnt", 64'(rd_cnt - start_rd), 64'(1));

    check_eq("rd_en_protocol", 64'(rd_viol), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
